// File: rtl/gpu_cmd_dispatcher_if.sv
// Register-bank command push, control/status and GPU start/done handshake for the dispatcher.
// master = register bank + GPU core side, slave = dispatcher.
interface gpu_cmd_dispatcher_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                  cmd_wr_en;
    logic [DATA_WIDTH-1:0] cmd_wr_data;
    logic                  cmd_full;
    logic [LVL_W-1:0]      cmd_level;
    logic                  ctrl_enable;
    logic                  ctrl_abort;
    logic                  irq_clear;
    logic                  gpu_start;
    logic [DATA_WIDTH-1:0] gpu_cmd;
    logic                  gpu_done;
    logic                  busy;
    logic                  err_timeout;
    logic                  err_overflow;
    logic                  irq;
    logic [CNT_WIDTH-1:0]  done_count;

    modport master (
        output cmd_wr_en, cmd_wr_data, ctrl_enable, ctrl_abort, irq_clear, gpu_done,
        input  cmd_full, cmd_level, gpu_start, gpu_cmd, busy, err_timeout, err_overflow,
               irq, done_count
    );

    modport slave (
        input  cmd_wr_en, cmd_wr_data, ctrl_enable, ctrl_abort, irq_clear, gpu_done,
        output cmd_full, cmd_level, gpu_start, gpu_cmd, busy, err_timeout, err_overflow,
               irq, done_count
    );
endinterface

// File: rtl/gpu_cmd_dispatcher.sv
// Queues command words in a FIFO and launches them one at a time to the GPU core under a watchdog.
// Latency: pop in IDLE -> gpu_start next cycle; gpu_done -> next gpu_start is at least 3 cycles.
// Backpressure: cmd_full advertises a full FIFO; a push while full is dropped and flagged in err_overflow.
module gpu_cmd_dispatcher #(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    gpu_cmd_dispatcher_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_COMPLETE, S_HALT} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level;
    logic [WW-1:0]         wdog;
    logic [DATA_WIDTH-1:0] gpu_cmd_q;
    logic [CNT_WIDTH-1:0]  done_count_q;
    logic                  gpu_start_q, busy_q, err_timeout_q, err_overflow_q, irq_q;
    logic                  fifo_full, fifo_empty, push_ok, push_drop, launch, job_done, wd_expire;

    assign fifo_full  = (level == DEPTH_L);
    assign fifo_empty = (level == '0);

    // Abort overrides everything in its cycle, including a coincident push.
    always_comb begin
        push_ok   = bus.cmd_wr_en && !fifo_full && !bus.ctrl_abort;
        push_drop = bus.cmd_wr_en && fifo_full && !bus.ctrl_abort;
        launch    = (state == S_IDLE) && bus.ctrl_enable && !fifo_empty && !err_timeout_q
                    && !bus.ctrl_abort;
        job_done  = (state == S_RUN) && bus.gpu_done && !bus.ctrl_abort;
        wd_expire = (state == S_RUN) && !bus.gpu_done && (wdog == '0) && !bus.ctrl_abort;
    end

    always_ff @(posedge ACLK) begin
        if (push_ok) mem[wr_ptr] <= bus.cmd_wr_data;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (bus.ctrl_abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (launch)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, launch})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // The watchdog is loaded when the launch is committed so the gpu_start cycle is the
    // first of the TIMEOUT_CYCLES cycles the job is allowed.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= S_IDLE;
            gpu_start_q   <= 1'b0;
            gpu_cmd_q     <= '0;
            busy_q        <= 1'b0;
            wdog          <= '0;
            err_timeout_q <= 1'b0;
            done_count_q  <= '0;
        end else if (bus.ctrl_abort) begin
            state         <= S_IDLE;
            gpu_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (launch) begin
                    gpu_cmd_q   <= mem[rd_ptr];
                    gpu_start_q <= 1'b1;
                    busy_q      <= 1'b1;
                    wdog        <= WD_LOAD;
                    state       <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    gpu_start_q <= 1'b0;
                    wdog        <= wdog - WW'(1);
                    state       <= S_RUN;
                end
                S_RUN: begin
                    if (job_done) begin
                        busy_q       <= 1'b0;
                        done_count_q <= done_count_q + CNT_WIDTH'(1);
                        state        <= S_COMPLETE;
                    end else if (wd_expire) begin
                        busy_q        <= 1'b0;
                        err_timeout_q <= 1'b1;
                        state         <= S_HALT;
                    end else begin
                        wdog <= wdog - WW'(1);
                    end
                end
                S_COMPLETE: state <= S_IDLE;
                S_HALT:     state <= S_HALT;
                default:    state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_q          <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            if (job_done || wd_expire) irq_q <= 1'b1;
            else if (bus.irq_clear)    irq_q <= 1'b0;
            if (bus.ctrl_abort)        err_overflow_q <= 1'b0;
            else if (push_drop)        err_overflow_q <= 1'b1;
        end
    end

    assign bus.cmd_full     = fifo_full;
    assign bus.cmd_level    = level;
    assign bus.gpu_start    = gpu_start_q;
    assign bus.gpu_cmd      = gpu_cmd_q;
    assign bus.busy         = busy_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.err_overflow = err_overflow_q;
    assign bus.irq          = irq_q;
    assign bus.done_count   = done_count_q;
endmodule

// File: doc/gpu_cmd_dispatcher.md
Name: gpu_cmd_dispatcher

Overview:
Sequences draw/fill commands from the AXI4-Lite register bank into the GPU core. Register-bank writes to the command register push 32-bit command words into an internal FIFO. A dispatcher FSM launches one command at a time on a start/done handshake, guards each job with a watchdog, and reports status, a completion count and a level interrupt back to the register bank.

Parameters:
DATA_WIDTH, 32, command word width
FIFO_DEPTH, 8, command FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 1000000, max ACLK cycles from gpu_start to gpu_done before error
CNT_WIDTH, 16, width of completed-job counter

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
cmd_wr_en  in  1  one-cycle push strobe from register bank
cmd_wr_data  in  DATA_WIDTH  command word
cmd_full  out  1  FIFO full
cmd_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
ctrl_enable  in  1  dispatch enable (level)
ctrl_abort  in  1  one-cycle pulse: flush FIFO, clear error, return to IDLE
irq_clear  in  1  one-cycle pulse: clear irq
gpu_start  out  1  one-cycle launch pulse
gpu_cmd  out  DATA_WIDTH  command held stable from gpu_start until gpu_done
gpu_done  in  1  one-cycle completion pulse from GPU core
busy  out  1  job in flight
err_timeout  out  1  sticky watchdog error
err_overflow  out  1  sticky push-while-full error
irq  out  1  level interrupt, set on each completion or error
done_count  out  CNT_WIDTH  completed jobs, wraps

Behaviour:
- Async reset (ARESETN=0): all outputs 0, FIFO empty, FSM IDLE, counters 0. Deassertion is synchronised by the system; the block samples from the first ACLK edge with ARESETN=1.
- FIFO: synchronous, first-word-fall-through internally. A push when cmd_full=1 is dropped and sets err_overflow. Push and pop in the same cycle is allowed when not full: level unchanged. cmd_level counts 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: if ctrl_enable=1 and FIFO non-empty and err_timeout=0, pop the head, register it into gpu_cmd and go to LAUNCH.
  - LAUNCH: gpu_start=1 for exactly 1 cycle. busy=1. Load watchdog with TIMEOUT_CYCLES-1. Go to RUN.
  - RUN: busy=1, watchdog decrements each cycle. On gpu_done=1, go to COMPLETE. If the watchdog reaches 0 with no gpu_done, set err_timeout and irq, then go to HALT.
  - COMPLETE (1 cycle): done_count+1 (wraps), irq set, busy=0. Go to IDLE.
  - HALT: busy=0, no further launches. Exit only via ctrl_abort.
- Latency: from a pop in IDLE to gpu_start is 1 cycle. Back-to-back jobs have a minimum 3-cycle gap from gpu_done to the next gpu_start (COMPLETE, IDLE, LAUNCH).
- A gpu_done outside RUN is ignored.
- gpu_done in the same cycle the watchdog reaches 0: done wins, no error.
- ctrl_enable dropped during RUN: the current job finishes normally; no new launch.
- ctrl_abort in any state: FIFO flushed, err_timeout and err_overflow cleared, FSM to IDLE next cycle, busy=0. done_count and irq are unchanged. A push in the same cycle as abort is discarded.
- irq: set on completion or timeout, cleared by irq_clear. If set and clear coincide, set wins.
- gpu_cmd keeps its last value after completion.

Test Plan:
- Reset, then push 0x00000001..0x00000004 with ctrl_enable=1; GPU model returns gpu_done 5 cycles after each start -> four gpu_start pulses with gpu_cmd 1,2,3,4 in order; done_count=4; irq=1; cmd_level=0.
- ctrl_enable=0, push 9 words with FIFO_DEPTH=8 -> cmd_full=1 after the 8th push, err_overflow=1, cmd_level=8; enable -> exactly 8 jobs dispatched.
- TIMEOUT_CYCLES=16, GPU never asserts done -> err_timeout=1 exactly 16 cycles after gpu_start; busy=0; remaining queued command not launched; ctrl_abort -> errors cleared, cmd_level=0.
- gpu_done coincident with the final watchdog cycle -> no err_timeout, done_count increments.
- Assert irq_clear in the same cycle as a completion -> irq stays 1; a clear one cycle later -> irq=0.
- Assert ARESETN low mid-RUN with 3 queued words -> all outputs 0 immediately (asynchronous); after release, no gpu_start until new pushes arrive.
